pcie_rdram_arb: RTL and testbench
=================================

Name: pcie_rdram_arb

Overview:
- Round-robin arbiter and sequencer for the shared PCIe buffer-RAM read port (11-bit word address, 32-bit data, RAM_valid return strobe).
- Grants one requester at a time a burst (start address, length) and issues the reads with bounded outstanding depth.
- Forwards returned words tagged with requester ID, a last-word flag and a completion pulse.
- Sits between the read engines and the single RAM read port feeding the FPGA-side data path.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LEN_W, 8, burst length field width in words
- MAX_OUT, 4, maximum reads in flight (1..15)
- ID_W, 2, requester ID width (must equal clog2(NREQ))

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  global gate; low blocks new grants and new reads
- req_valid  in  NREQ  per-requester burst request, held until accepted
- req_addr  in  NREQ*11  per-requester start word address (slice i = requester i)
- req_len  in  NREQ*LEN_W  per-requester burst length in words
- req_ack  out  NREQ  one-cycle pulse when the request is captured
- req_done  out  NREQ  one-cycle pulse when the last word of a burst has returned
- RAM_addr  out  11  read address
- read_en  out  1  read strobe, one word per cycle
- RAM_data  in  32  read data
- RAM_valid  in  1  read data valid, in issue order, latency of 1 or more cycles
- FPGA_data  out  32  forwarded data
- FPGA_valid  out  1  forwarded data valid
- FPGA_id  out  ID_W  owner of the current FPGA_data word
- FPGA_last  out  1  current word is the last of its burst
- busy  out  1  state is not IDLE
- err_spurious  out  1  sticky flag: RAM_valid seen with zero outstanding reads

Behaviour:
- Reset values: all outputs 0, RR pointer 0, outstanding count 0, state IDLE.
- States:
  - IDLE: when enable=1 and any req_valid is set, grant the first requester at or after the RR pointer (round-robin).
    - Capture its address and length, pulse req_ack[g], set RR pointer to g+1 mod NREQ, go to ISSUE.
  - ISSUE: assert read_en with RAM_addr=cur_addr when enable=1, outstanding<MAX_OUT and remaining>0.
    - Each issued read increments cur_addr (mod 2048, so 2047 wraps to 0), decrements remaining and increments outstanding.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the returned-word count equals the burst length, then pulse req_done[g] and go to IDLE.
- Grant latency: req_valid sampled in IDLE gives req_ack in the next cycle and the first read_en in the cycle after that.
- Back-to-back bursts: the next grant is made in the cycle after req_done. Bursts never overlap.
- Outstanding counter:
  - +1 on read_en, -1 on accepted RAM_valid, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT.
- Return path:
  - When RAM_valid=1 and outstanding>0: FPGA_data=RAM_data, FPGA_valid=1, FPGA_id=g, registered with 1-cycle latency.
  - FPGA_last=1 on the word whose return count equals the burst length.
  - req_done[g] is asserted in the same cycle as FPGA_last.
- Spurious return: RAM_valid while outstanding=0 is dropped (no FPGA_valid) and sets err_spurious. err_spurious clears only on rst.
- req_len=0: the request is acknowledged and no reads are issued. req_done pulses one cycle after req_ack, then the block returns to IDLE.
- enable low mid-burst: read_en stops and the state is held. In-flight returns are still forwarded. Issue resumes when enable returns high.
- req_valid dropped after grant: ignored, the captured burst completes.
- Reset asserted mid-burst: immediate return to reset values. Late RAM_valid after reset sets err_spurious.

Decomposition:
- Shared package pcie_rdram_pkg:
  - typedef ram_addr_t (logic[10:0]), ram_word_t (logic[31:0]).
  - State enum arb_state_t {IDLE, ISSUE, DRAIN}.
  - Constant RAM_DEPTH=2048.
- One sub-module: rr_arbiter (NREQ request vector and pointer in, one-hot grant and index out, combinational). FSM and counters stay in the top.

Test Plan:
- Single request: req0 addr=0x010, len=3, RAM latency 1, data 0xfeadbeef/0xffffffff/0x12345678 -> read_en with addrs 0x010, 0x011, 0x012. Three FPGA_valid words with id=0, FPGA_last on the third, req_done[0] in the same cycle.
- Round-robin: req1 and req3 both held with len=2 from reset -> req3 not granted until req1 is done. Order is 1, 3, then 1 again if it re-requests; the pointer skips 0 and 2.
- Outstanding limit: MAX_OUT=4, RAM latency 10, len=8 -> 4 reads issued, read_en low until the first RAM_valid, never more than 4 in flight. All 8 words delivered in order.
- Wrap: addr=0x7FE, len=4 -> RAM_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length and enable gating: len=0 -> req_ack then req_done next cycle, no read_en. Mid-burst enable=0 for 5 cycles -> no read_en during the gap, the burst completes after re-enable.
- Spurious and reset: RAM_valid=1 while idle -> no FPGA_valid, err_spurious=1. rst pulse during ISSUE -> all outputs 0 and err_spurious cleared.

Source files
------------

// File: rtl/pcie_rdram_pkg.sv
// Shared types and constants for the PCIe buffer-RAM read arbiter.
package pcie_rdram_pkg;

    localparam int RAM_DEPTH = 2048;

    typedef logic [10:0] ram_addr_t;
    typedef logic [31:0] ram_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pcie_rdram_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_valid
);

    // scan from the pointer, wrapping at NREQ (which need not be a power of two)
    always_comb begin : rr_scan
        int j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gnt_valid && req[j]) begin
                gnt[j]    = 1'b1;
                gnt_idx   = ID_W'(j);
                gnt_valid = 1'b1;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/pcie_rdram_arb.sv
// Round-robin burst arbiter and read sequencer for the shared PCIe buffer-RAM read port.
module pcie_rdram_arb
    import pcie_rdram_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 8,
    parameter int MAX_OUT = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*11-1:0]    req_addr,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       req_done,
    output logic [10:0]           RAM_addr,
    output logic                  read_en,
    input  logic [31:0]           RAM_data,
    input  logic                  RAM_valid,
    output logic [31:0]           FPGA_data,
    output logic                  FPGA_valid,
    output logic [ID_W-1:0]       FPGA_id,
    output logic                  FPGA_last,
    output logic                  busy,
    output logic                  err_spurious
);

    localparam int OUT_W = 4;

    arb_state_t       state_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  owner_r;
    ram_addr_t        cur_addr_r;
    logic [LEN_W-1:0] rem_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] ret_cnt_r;
    logic [OUT_W-1:0] out_r;
    logic [NREQ-1:0]  req_ack_r;
    logic [NREQ-1:0]  req_done_r;
    ram_addr_t        ram_addr_r;
    logic             read_en_r;
    ram_word_t        fpga_data_r;
    logic             fpga_valid_r;
    logic [ID_W-1:0]  fpga_id_r;
    logic             fpga_last_r;
    logic             err_spurious_r;

    logic [NREQ-1:0]  gnt_s;
    logic [ID_W-1:0]  gnt_idx_s;
    logic             gnt_valid_s;
    logic [ID_W-1:0]  rr_next_s;
    ram_addr_t        grant_addr_s;
    logic [LEN_W-1:0] grant_len_s;
    logic             issue_s;
    logic             ret_ok_s;
    logic [LEN_W-1:0] ret_next_s;
    logic             ret_last_s;
    logic [NREQ-1:0]  done_vec_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .gnt       (gnt_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // grant selection, issue qualification and return bookkeeping
    always_comb begin
        grant_addr_s = req_addr[int'(gnt_idx_s)*11 +: 11];
        grant_len_s  = req_len[int'(gnt_idx_s)*LEN_W +: LEN_W];
        if (int'(gnt_idx_s) == NREQ - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_s + ID_W'(1);
        end
        issue_s    = (state_r == ISSUE) && enable && (out_r < OUT_W'(MAX_OUT)) && (rem_r != '0);
        ret_ok_s   = RAM_valid && (out_r != '0);
        ret_next_s = ret_cnt_r + LEN_W'(1);
        ret_last_s = ret_ok_s && (ret_next_s == len_r);
        done_vec_s = NREQ'(1) << owner_r;
    end

    // burst FSM, read issue and return forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            rr_ptr_r       <= '0;
            owner_r        <= '0;
            cur_addr_r     <= '0;
            rem_r          <= '0;
            len_r          <= '0;
            ret_cnt_r      <= '0;
            req_ack_r      <= '0;
            req_done_r     <= '0;
            ram_addr_r     <= '0;
            read_en_r      <= 1'b0;
            fpga_data_r    <= '0;
            fpga_valid_r   <= 1'b0;
            fpga_id_r      <= '0;
            fpga_last_r    <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            req_ack_r    <= '0;
            req_done_r   <= '0;
            read_en_r    <= 1'b0;
            fpga_valid_r <= 1'b0;
            fpga_last_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable && gnt_valid_s) begin
                        state_r    <= ISSUE;
                        req_ack_r  <= gnt_s;
                        owner_r    <= gnt_idx_s;
                        cur_addr_r <= grant_addr_s;
                        rem_r      <= grant_len_s;
                        len_r      <= grant_len_s;
                        ret_cnt_r  <= '0;
                        rr_ptr_r   <= rr_next_s;
                    end
                end
                ISSUE: begin
                    if (len_r == '0) begin
                        req_done_r <= done_vec_s;
                        state_r    <= IDLE;
                    end else if (issue_s) begin
                        read_en_r  <= 1'b1;
                        ram_addr_r <= cur_addr_r;
                        cur_addr_r <= cur_addr_r + 11'd1;
                        rem_r      <= rem_r - LEN_W'(1);
                        if (rem_r == LEN_W'(1)) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state_r <= DRAIN;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // returns are forwarded in any state so enable-low gaps keep draining
            if (ret_ok_s) begin
                fpga_valid_r <= 1'b1;
                fpga_data_r  <= RAM_data;
                fpga_id_r    <= owner_r;
                ret_cnt_r    <= ret_next_s;
                if (ret_last_s) begin
                    fpga_last_r <= 1'b1;
                    req_done_r  <= done_vec_s;
                    state_r     <= IDLE;
                end
            end
            if (RAM_valid && (out_r == '0)) begin
                err_spurious_r <= 1'b1;
            end
        end
    end

    // reads in flight: counted from the issue decision until the word returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= '0;
        end else begin
            case ({issue_s, ret_ok_s})
                2'b10:   out_r <= out_r + OUT_W'(1);
                2'b01:   out_r <= out_r - OUT_W'(1);
                default: out_r <= out_r;
            endcase
        end
    end

    assign req_ack      = req_ack_r;
    assign req_done     = req_done_r;
    assign RAM_addr     = ram_addr_r;
    assign read_en      = read_en_r;
    assign FPGA_data    = fpga_data_r;
    assign FPGA_valid   = fpga_valid_r;
    assign FPGA_id      = fpga_id_r;
    assign FPGA_last    = fpga_last_r;
    assign busy         = (state_r != IDLE);
    assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_pcie_rdram_arb.sv
// Directed self-checking bench for pcie_rdram_arb with a fixed-latency RAM model.
module tb_pcie_rdram_arb;

    localparam int NREQ    = 4;
    localparam int LEN_W   = 8;
    localparam int MAX_OUT = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*11-1:0]    req_addr = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       req_done;
    logic [10:0]           RAM_addr;
    logic                  read_en;
    logic [31:0]           RAM_data;
    logic                  RAM_valid;
    logic [31:0]           FPGA_data;
    logic                  FPGA_valid;
    logic [ID_W-1:0]       FPGA_id;
    logic                  FPGA_last;
    logic                  busy;
    logic                  err_spurious;

    logic        m_valid = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic        sp_valid = 1'b0;
    assign RAM_valid = m_valid | sp_valid;
    assign RAM_data  = m_data;

    int checks = 0;
    int errors = 0;

    pcie_rdram_arb #(
        .NREQ(NREQ), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .req_done(req_done),
        .RAM_addr(RAM_addr), .read_en(read_en),
        .RAM_data(RAM_data), .RAM_valid(RAM_valid),
        .FPGA_data(FPGA_data), .FPGA_valid(FPGA_valid), .FPGA_id(FPGA_id),
        .FPGA_last(FPGA_last), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // RAM model: read seen in cycle c returns in cycle c+lat, in order
    logic [31:0] mem [0:2047];
    int          lat = 1;
    int          cyc = 0;
    int          inflight = 0;
    int          max_inflight = 0;
    int          due_q[$];
    logic [10:0] paddr_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            m_valid = 1'b1;
            m_data  = mem[paddr_q[0]];
            void'(due_q.pop_front());
            void'(paddr_q.pop_front());
            inflight = inflight - 1;
        end else begin
            m_valid = 1'b0;
            m_data  = 32'h0;
        end
        if (read_en) begin
            due_q.push_back(cyc + lat);
            paddr_q.push_back(RAM_addr);
            inflight = inflight + 1;
            if (inflight > max_inflight) max_inflight = inflight;
        end
    end

    logic [10:0]     rd_addr_q[$];
    int              rd_step_q[$];
    logic [31:0]     fw_data_q[$];
    logic [ID_W-1:0] fw_id_q[$];
    logic            fw_last_q[$];
    int              fw_step_q[$];
    int              ack_q[$];
    int              ack_step_q[$];
    int              done_q[$];
    int              done_step_q[$];
    logic            busy_q[$];
    int              hold_cnt[NREQ];

    task automatic clear_logs();
        rd_addr_q.delete(); rd_step_q.delete();
        fw_data_q.delete(); fw_id_q.delete(); fw_last_q.delete(); fw_step_q.delete();
        ack_q.delete(); ack_step_q.delete(); done_q.delete(); done_step_q.delete();
        busy_q.delete();
    endtask

    task automatic set_req(input int i, input logic [10:0] a, input logic [LEN_W-1:0] l, input int holds);
        req_addr[i*11 +: 11]       = a;
        req_len[i*LEN_W +: LEN_W]  = l;
        hold_cnt[i]                = holds;
        req_valid[i]               = 1'b1;
    endtask

    // run ncyc cycles logging DUT activity; enable is low for steps gap_lo..gap_hi-1
    task automatic collect(input int ncyc, input int gap_lo, input int gap_hi);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            busy_q.push_back(busy);
            if (read_en) begin
                rd_addr_q.push_back(RAM_addr);
                rd_step_q.push_back(c);
            end
            if (FPGA_valid) begin
                fw_data_q.push_back(FPGA_data);
                fw_id_q.push_back(FPGA_id);
                fw_last_q.push_back(FPGA_last);
                fw_step_q.push_back(c);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    ack_q.push_back(i);
                    ack_step_q.push_back(c);
                    if (hold_cnt[i] > 0) hold_cnt[i] = hold_cnt[i] - 1;
                    if (hold_cnt[i] == 0) req_valid[i] = 1'b0;
                end
                if (req_done[i]) begin
                    done_q.push_back(i);
                    done_step_q.push_back(c);
                end
            end
            if (c == gap_lo) enable = 1'b0;
            if (c == gap_hi) enable = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ack, req_done, RAM_addr, read_en, FPGA_data, FPGA_valid, FPGA_id, FPGA_last, err_spurious} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_ack, req_done, RAM_addr, read_en, FPGA_data, FPGA_valid, FPGA_id, FPGA_last, err_spurious});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_ack[3] = '{1, 3, 1};
        int exp_ack_step[3] = '{1, 6, 11};
        logic [10:0] exp_addr[6] = '{11'h300, 11'h301, 11'h400, 11'h401, 11'h300, 11'h301};
        logic [ID_W-1:0] exp_id[6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
        clear_logs();
        lat = 1;
        set_req(1, 11'h300, 8'd2, 2);
        set_req(3, 11'h400, 8'd2, 1);
        collect(20, 0, 0);
        checks++;
        if (ack_q.size() != 3 || done_q.size() != 3 || rd_addr_q.size() != 6 || fw_id_q.size() != 6) begin
            errors++;
            $display("FAIL rr_counts: acks %0d dones %0d reads %0d words %0d expected 3 3 6 6",
                     ack_q.size(), done_q.size(), rd_addr_q.size(), fw_id_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ack_q[i] != exp_ack[i] || ack_step_q[i] != exp_ack_step[i] || done_q[i] != exp_ack[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: ack %0d@%0d done %0d expected %0d@%0d",
                             i, ack_q[i], ack_step_q[i], done_q[i], exp_ack[i], exp_ack_step[i]);
                end
            end
            checks++;
            if (ack_step_q[1] != done_step_q[0] + 1) begin
                errors++;
                $display("FAIL rr_no_overlap: second ack at %0d expected %0d", ack_step_q[1], done_step_q[0] + 1);
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rd_addr_q[i] !== exp_addr[i] || fw_id_q[i] !== exp_id[i]) begin
                    errors++;
                    $display("FAIL rr_word[%0d]: addr %h id %0d expected addr %h id %0d",
                             i, rd_addr_q[i], fw_id_q[i], exp_addr[i], exp_id[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_d[3] = '{32'hfeadbeef, 32'hffffffff, 32'h12345678};
        logic [10:0] exp_a[3] = '{11'h010, 11'h011, 11'h012};
        logic        exp_l[3] = '{1'b0, 1'b0, 1'b1};
        clear_logs();
        lat = 1;
        mem[11'h010] = 32'hfeadbeef;
        mem[11'h011] = 32'hffffffff;
        mem[11'h012] = 32'h12345678;
        set_req(0, 11'h010, 8'd3, 1);
        collect(12, 0, 0);
        checks++;
        if (ack_q.size() != 1 || rd_step_q.size() != 3 || fw_data_q.size() != 3 || done_q.size() != 1) begin
            errors++;
            $display("FAIL single_counts: acks %0d reads %0d words %0d dones %0d expected 1 3 3 1",
                     ack_q.size(), rd_step_q.size(), fw_data_q.size(), done_q.size());
        end else begin
            checks++;
            if (ack_q[0] != 0 || ack_step_q[0] != 1 || rd_step_q[0] != 2) begin
                errors++;
                $display("FAIL single_latency: ack %0d@%0d first read@%0d expected 0@1 read@2",
                         ack_q[0], ack_step_q[0], rd_step_q[0]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_addr_q[i] !== exp_a[i] || fw_data_q[i] !== exp_d[i] || fw_id_q[i] !== 2'd0 || fw_last_q[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL single_word[%0d]: addr %h data %h id %0d last %b expected %h %h 0 %b",
                             i, rd_addr_q[i], fw_data_q[i], fw_id_q[i], fw_last_q[i], exp_a[i], exp_d[i], exp_l[i]);
                end
            end
            checks++;
            if (done_q[0] != 0 || done_step_q[0] != fw_step_q[2] || fw_step_q[2] != 6) begin
                errors++;
                $display("FAIL single_done: done %0d@%0d last word@%0d expected 0@6",
                         done_q[0], done_step_q[0], fw_step_q[2]);
            end
        end
    endtask

    task automatic test_outstanding();
        int early;
        clear_logs();
        lat = 10;
        max_inflight = 0;
        set_req(2, 11'h500, 8'd8, 1);
        collect(60, 0, 0);
        early = 0;
        foreach (rd_step_q[i]) if (rd_step_q[i] <= 12) early++;
        checks++;
        if (early != MAX_OUT) begin
            errors++;
            $display("FAIL outst_early_reads: got %0d reads before first return expected %0d", early, MAX_OUT);
        end
        checks++;
        if (max_inflight != MAX_OUT) begin
            errors++;
            $display("FAIL outst_max: got %0d in flight expected %0d", max_inflight, MAX_OUT);
        end
        checks++;
        if (fw_data_q.size() != 8 || done_q.size() != 1) begin
            errors++;
            $display("FAIL outst_counts: words %0d dones %0d expected 8 1", fw_data_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (fw_data_q[i] !== mem[11'h500 + i] || fw_id_q[i] !== 2'd2 || fw_last_q[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL outst_word[%0d]: data %h id %0d last %b expected %h 2 %b",
                             i, fw_data_q[i], fw_id_q[i], fw_last_q[i], mem[11'h500 + i], (i == 7));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a[4] = '{11'h7fe, 11'h7ff, 11'h000, 11'h001};
        clear_logs();
        lat = 2;
        set_req(3, 11'h7fe, 8'd4, 1);
        collect(16, 0, 0);
        checks++;
        if (rd_addr_q.size() != 4 || fw_data_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts: reads %0d words %0d expected 4 4", rd_addr_q.size(), fw_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addr_q[i] !== exp_a[i] || fw_data_q[i] !== mem[exp_a[i]]) begin
                    errors++;
                    $display("FAIL wrap_word[%0d]: addr %h data %h expected %h %h",
                             i, rd_addr_q[i], fw_data_q[i], exp_a[i], mem[exp_a[i]]);
                end
            end
        end
    endtask

    task automatic test_zero_len_enable();
        int gap_reads;
        clear_logs();
        lat = 1;
        set_req(2, 11'h123, 8'd0, 1);
        collect(6, 0, 0);
        checks++;
        if (ack_q.size() != 1 || done_q.size() != 1 || rd_addr_q.size() != 0 || fw_data_q.size() != 0) begin
            errors++;
            $display("FAIL zero_counts: acks %0d dones %0d reads %0d words %0d expected 1 1 0 0",
                     ack_q.size(), done_q.size(), rd_addr_q.size(), fw_data_q.size());
        end else begin
            checks++;
            if (ack_q[0] != 2 || ack_step_q[0] != 1 || done_q[0] != 2 || done_step_q[0] != 2) begin
                errors++;
                $display("FAIL zero_timing: ack %0d@%0d done %0d@%0d expected 2@1 2@2",
                         ack_q[0], ack_step_q[0], done_q[0], done_step_q[0]);
            end
        end

        clear_logs();
        set_req(0, 11'h100, 8'd8, 1);
        collect(24, 4, 9);
        gap_reads = 0;
        foreach (rd_step_q[i]) if (rd_step_q[i] >= 5 && rd_step_q[i] <= 9) gap_reads++;
        checks++;
        if (gap_reads != 0) begin
            errors++;
            $display("FAIL gate_no_reads: got %0d reads in gap expected 0", gap_reads);
        end
        checks++;
        if (rd_step_q.size() != 8 || fw_data_q.size() != 8 || done_q.size() != 1) begin
            errors++;
            $display("FAIL gate_counts: reads %0d words %0d dones %0d expected 8 8 1",
                     rd_step_q.size(), fw_data_q.size(), done_q.size());
        end else begin
            checks++;
            if (rd_step_q[2] != 4 || rd_step_q[3] != 10 || fw_step_q[2] != 6 || busy_q[6] !== 1'b1) begin
                errors++;
                $display("FAIL gate_timing: 3rd read@%0d 4th read@%0d 3rd word@%0d busy %b expected 4 10 6 1",
                         rd_step_q[2], rd_step_q[3], fw_step_q[2], busy_q[6]);
            end
            checks++;
            if (fw_data_q[7] !== mem[11'h107] || fw_last_q[7] !== 1'b1) begin
                errors++;
                $display("FAIL gate_last: data %h last %b expected %h 1", fw_data_q[7], fw_last_q[7], mem[11'h107]);
            end
        end
    endtask

    task automatic test_spurious_reset();
        @(posedge clk); #1;
        sp_valid = 1'b1;
        @(posedge clk); #1;
        sp_valid = 1'b0;
        checks++;
        if (FPGA_valid !== 1'b0 || err_spurious !== 1'b1) begin
            errors++;
            $display("FAIL spurious_idle: valid %b err %b expected 0 1", FPGA_valid, err_spurious);
        end

        clear_logs();
        lat = 3;
        set_req(1, 11'h200, 8'd8, 1);
        collect(3, 0, 0);
        checks++;
        if (busy !== 1'b1 || rd_addr_q.size() != 2) begin
            errors++;
            $display("FAIL reset_setup: busy %b reads %0d expected 1 2", busy, rd_addr_q.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ack, req_done, RAM_addr, read_en, FPGA_data, FPGA_valid, FPGA_id, FPGA_last, busy, err_spurious} !== '0) begin
            errors++;
            $display("FAIL reset_mid_burst: got %h expected 0",
                     {req_ack, req_done, RAM_addr, read_en, FPGA_data, FPGA_valid, FPGA_id, FPGA_last, busy, err_spurious});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        collect(6, 0, 0);
        checks++;
        if (err_spurious !== 1'b1 || fw_data_q.size() != 0 || rd_addr_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_return: err %b words %0d reads %0d busy %b expected 1 0 0 0",
                     err_spurious, fw_data_q.size(), rd_addr_q.size(), busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = {5'h15, i[10:0], 5'h0a, ~i[10:0]};
        test_reset();
        test_round_robin();
        test_single();
        test_outstanding();
        test_wrap();
        test_zero_len_enable();
        test_spurious_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
